multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; sampled on clk rising edge.
REQ-004 opcode  input  4  instruction bits [15:12] from the instruction register.
REQ-005 zero  input  1  ALU zero flag (1 when ALU result == 16'd0).
REQ-006 mem_ready  input  1  memory handshake; access completes on any clk edge where the request is high and mem_ready=1.
REQ-007 state  output  4  current FSM state code, for debug and verification.
REQ-008 alu_control  output  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 100 slt.
REQ-009 alu_src_a  output  1  0=PC, 1=reg A.
REQ-010 alu_src_b  output  2  00=reg B, 01=const 1, 10=zero-extended imm, 11=sign-extended imm.
REQ-011 pc_src  output  2  00=ALU result, 01=ALUOut, 10=jump target.
REQ-012 pc_write, ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg, halted  output  1 each  standard datapath strobes/selects; iord 0=PC address, 1=ALUOut address; reg_dst 1=rd, 0=rt.

Function
REQ-013 The block SHALL use Moore outputs decoded only from state, except pc_write and ir_write, which SHALL also use zero and mem_ready as listed below; every output not listed for a state SHALL be 0.
REQ-014 State codes SHALL be: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, RWB 4, MEM_ADDR 5, MEM_READ 6, MEM_WB 7, MEM_WRITE 8, BRANCH 9, JUMP 10, IWB 11, HALT 15. Codes 12-14 SHALL go to FETCH on the next edge.
REQ-015 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_control=000, pc_src=00, ir_write=pc_write=mem_ready. Stay while mem_ready=0; go to DECODE when mem_ready=1.
REQ-016 DECODE: alu_src_a=0, alu_src_b=11, alu_control=000 (branch target into ALUOut). Next state by opcode: 0000-0100 -> EXEC_R; 0101 -> EXEC_I; 0110/0111 -> MEM_ADDR; 1000 -> BRANCH; 1001 -> JUMP; 1111 -> HALT; 1010-1110 -> FETCH (illegal opcode acts as NOP, no write strobes).
REQ-017 EXEC_R: alu_src_a=1, alu_src_b=00, alu_control=opcode[2:0] (0000 add ... 0100 slt); go to RWB.
REQ-018 RWB: reg_write=1, reg_dst=1, mem_to_reg=0; go to FETCH.
REQ-019 EXEC_I (ADDI): alu_src_a=1, alu_src_b=11, alu_control=000; go to IWB.
REQ-020 IWB: reg_write=1, reg_dst=0, mem_to_reg=0; go to FETCH.
REQ-021 MEM_ADDR: alu_src_a=1, alu_src_b=11, alu_control=000. For LW (0110) go to MEM_READ; for SW (0111) go to MEM_WRITE. The opcode SHALL be re-sampled here (the IR is stable).
REQ-022 MEM_READ: mem_read=1, iord=1. Stay while mem_ready=0; go to MEM_WB when mem_ready=1.
REQ-023 MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1; go to FETCH.
REQ-024 MEM_WRITE: mem_write=1, iord=1. Stay while mem_ready=0; go to FETCH when mem_ready=1. mem_write SHALL stay high for every wait cycle.
REQ-025 BRANCH: alu_src_a=1, alu_src_b=00, alu_control=001, pc_src=01, pc_write=zero; go to FETCH.
REQ-026 JUMP: pc_src=10, pc_write=1; go to FETCH.
REQ-027 HALT: halted=1, all write strobes 0. The FSM SHALL stay in HALT until reset.
REQ-028 Latency with mem_ready held at 1: R-type/ADDI 4 cycles, LW 5, SW 4, BEQ 3, J 3, illegal 2. Each cycle of mem_ready=0 in a memory state SHALL add exactly one cycle.
REQ-029 The block SHALL issue at most one memory request (mem_read or mem_write) per cycle, and never both.

Reset
REQ-030 When reset=1 at a clk edge, state SHALL become FETCH (0) regardless of the current state, including the wait cycles of HALT and the memory states.
REQ-031 While reset=1, pc_write, ir_write, reg_write, mem_write and halted SHALL be forced to 0; the other outputs follow the FETCH decode.
REQ-032 Reset SHALL take priority over every other state transition.

Verification
REQ-033 After reset, mem_ready=1, opcode=0000 -> state sequence 0,1,2,4,0; reg_write=1 and reg_dst=1 only in state 4; alu_control=000 in state 2.
REQ-034 opcode=0110, mem_ready low for 3 cycles in MEM_READ -> sequence 0,1,5,6,6,6,6,7,0; mem_read=1 and iord=1 throughout state 6; mem_to_reg=1 in state 7.
REQ-035 opcode=1000 with zero=1, then zero=0 -> pc_write=1 with pc_src=01 in BRANCH for the first run, pc_write=0 for the second; alu_control=001 in both.
REQ-036 opcode=0111, mem_ready=0 for 2 cycles -> mem_write=1 for 3 consecutive cycles, then state=0; reg_write stays 0 throughout.
REQ-037 opcode=1111 -> state=15 and halted=1 held for 10+ cycles; reset pulse -> state=0 and halted=0 on the next edge.
REQ-038 opcode=1011 -> sequence 0,1,0 with no write strobe asserted in DECODE; reset asserted during MEM_WRITE wait -> state=0 next edge, mem_write=0.

Source files
------------

// File: rtl/multicycle_control_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_if
//   Signal bundle between the multicycle controller and its datapath/memory.
//   master : the controller (receives opcode/zero/mem_ready, drives controls)
//   slave  : the datapath side (drives opcode/zero/mem_ready, receives controls)
//
//   opcode[3:0]      instruction bits [15:12] from the IR
//   zero             ALU zero flag
//   mem_ready        memory handshake, completes an access when high
//   state[3:0]       current FSM state code (debug/verification)
//   alu_control[2:0] 000 add, 001 sub, 010 and, 011 or, 100 slt
//   alu_src_a        0=PC, 1=reg A
//   alu_src_b[1:0]   00=reg B, 01=const 1, 10=zext imm, 11=sext imm
//   pc_src[1:0]      00=ALU result, 01=ALUOut, 10=jump target
//   pc_write, ir_write, mem_read, mem_write, iord, reg_write, reg_dst,
//   mem_to_reg, halted : datapath strobes/selects
// ---------------------------------------------------------------------------
interface multicycle_control_if;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic [3:0] state;
    logic [2:0] alu_control;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       halted;

    modport master (
        input  opcode, zero, mem_ready,
        output state, alu_control, alu_src_a, alu_src_b, pc_src,
               pc_write, ir_write, mem_read, mem_write, iord,
               reg_write, reg_dst, mem_to_reg, halted
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  state, alu_control, alu_src_a, alu_src_b, pc_src,
               pc_write, ir_write, mem_read, mem_write, iord,
               reg_write, reg_dst, mem_to_reg, halted
    );
endinterface

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   Moore-style control FSM for a multicycle 16-bit processor.
//   clk   : rising-edge clock for all state
//   reset : synchronous, active-high; returns the FSM to FETCH
//   bus   : multicycle_control_if.master (opcode/zero/mem_ready in,
//           state code and all datapath controls out)
// ---------------------------------------------------------------------------
module multicycle_control (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        EXEC_R    = 4'd2,
        EXEC_I    = 4'd3,
        RWB       = 4'd4,
        MEM_ADDR  = 4'd5,
        MEM_READ  = 4'd6,
        MEM_WB    = 4'd7,
        MEM_WRITE = 4'd8,
        BRANCH    = 4'd9,
        JUMP      = 4'd10,
        IWB       = 4'd11,
        HALT      = 4'd15
    } state_t;

    state_t state_q;
    state_t state_d;
    state_t decode_st;

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= FETCH;
        else
            state_q <= state_d;
    end

    // Next-state logic; unused codes 12-14 fall through to FETCH.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = bus.mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (bus.opcode)
                    4'b0000, 4'b0001, 4'b0010,
                    4'b0011, 4'b0100:  state_d = EXEC_R;
                    4'b0101:           state_d = EXEC_I;
                    4'b0110, 4'b0111:  state_d = MEM_ADDR;
                    4'b1000:           state_d = BRANCH;
                    4'b1001:           state_d = JUMP;
                    4'b1111:           state_d = HALT;
                    default:           state_d = FETCH;
                endcase
            end
            EXEC_R:   state_d = RWB;
            RWB:      state_d = FETCH;
            EXEC_I:   state_d = IWB;
            IWB:      state_d = FETCH;
            MEM_ADDR: begin
                case (bus.opcode)
                    4'b0110: state_d = MEM_READ;
                    4'b0111: state_d = MEM_WRITE;
                    default: state_d = FETCH;
                endcase
            end
            MEM_READ:  state_d = bus.mem_ready ? MEM_WB : MEM_READ;
            MEM_WB:    state_d = FETCH;
            MEM_WRITE: state_d = bus.mem_ready ? FETCH : MEM_WRITE;
            BRANCH:    state_d = FETCH;
            JUMP:      state_d = FETCH;
            HALT:      state_d = HALT;
            default:   state_d = FETCH;
        endcase
    end

    // Output decode. While reset is high the outputs follow the FETCH
    // decode with every write strobe and halted forced low.
    always_comb begin
        decode_st       = reset ? FETCH : state_q;
        bus.alu_control = 3'b000;
        bus.alu_src_a   = 1'b0;
        bus.alu_src_b   = 2'b00;
        bus.pc_src      = 2'b00;
        bus.pc_write    = 1'b0;
        bus.ir_write    = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.iord        = 1'b0;
        bus.reg_write   = 1'b0;
        bus.reg_dst     = 1'b0;
        bus.mem_to_reg  = 1'b0;
        bus.halted      = 1'b0;
        case (decode_st)
            FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.pc_write  = bus.mem_ready;
                bus.ir_write  = bus.mem_ready;
            end
            DECODE: begin
                bus.alu_src_b = 2'b11;
            end
            EXEC_R: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_control = bus.opcode[2:0];
            end
            RWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            EXEC_I, MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b11;
            end
            IWB: begin
                bus.reg_write = 1'b1;
            end
            MEM_READ: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
            end
            MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            MEM_WRITE: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
            end
            BRANCH: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_control = 3'b001;
                bus.pc_src      = 2'b01;
                bus.pc_write    = bus.zero;
            end
            JUMP: begin
                bus.pc_src   = 2'b10;
                bus.pc_write = 1'b1;
            end
            HALT: begin
                bus.halted = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            bus.pc_write  = 1'b0;
            bus.ir_write  = 1'b0;
            bus.reg_write = 1'b0;
            bus.mem_write = 1'b0;
            bus.halted    = 1'b0;
        end
    end

    assign bus.state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//   Directed per-cycle stimulus for multicycle_control. Each stimulus cycle
//   pushes the hand-written expected state plus the expected control outputs
//   for that state into a queue; a monitor pops one entry per falling edge
//   and compares it with the full DUT output bundle.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

    typedef struct packed {
        logic [3:0] state;
        logic [2:0] alu_control;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       halted;
    } out_t;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    int   step_no;
    out_t exp_q[$];

    multicycle_control_if bus_if ();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected controls for a given state code, from the state table.
    function automatic out_t model(input logic [3:0] st, input logic [3:0] op,
                                   input logic z, input logic mr, input logic rst);
        out_t o;
        o       = '0;
        o.state = st;
        case (rst ? 4'd0 : st)
            4'd0:  begin o.mem_read = 1'b1; o.alu_src_b = 2'b01;
                         o.pc_write = mr; o.ir_write = mr; end
            4'd1:  o.alu_src_b = 2'b11;
            4'd2:  begin o.alu_src_a = 1'b1; o.alu_control = op[2:0]; end
            4'd3:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b11; end
            4'd4:  begin o.reg_write = 1'b1; o.reg_dst = 1'b1; end
            4'd5:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b11; end
            4'd6:  begin o.mem_read = 1'b1; o.iord = 1'b1; end
            4'd7:  begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end
            4'd8:  begin o.mem_write = 1'b1; o.iord = 1'b1; end
            4'd9:  begin o.alu_src_a = 1'b1; o.alu_control = 3'b001;
                         o.pc_src = 2'b01; o.pc_write = z; end
            4'd10: begin o.pc_src = 2'b10; o.pc_write = 1'b1; end
            4'd11: o.reg_write = 1'b1;
            4'd15: o.halted = 1'b1;
            default: ;
        endcase
        if (rst) begin
            o.pc_write = 1'b0;
            o.ir_write = 1'b0;
        end
        return o;
    endfunction

    // One clock cycle: st is the state expected during this cycle, the
    // remaining arguments are the inputs applied during it.
    task automatic cyc(input logic [3:0] st, input logic [3:0] op,
                       input logic z, input logic mr, input logic rst);
        @(posedge clk);
        #1;
        reset            = rst;
        bus_if.opcode    = op;
        bus_if.zero      = z;
        bus_if.mem_ready = mr;
        exp_q.push_back(model(st, op, z, mr, rst));
    endtask

    // Monitor / scoreboard
    initial begin
        out_t act;
        out_t e;
        step_no = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act.state       = bus_if.state;
                act.alu_control = bus_if.alu_control;
                act.alu_src_a   = bus_if.alu_src_a;
                act.alu_src_b   = bus_if.alu_src_b;
                act.pc_src      = bus_if.pc_src;
                act.pc_write    = bus_if.pc_write;
                act.ir_write    = bus_if.ir_write;
                act.mem_read    = bus_if.mem_read;
                act.mem_write   = bus_if.mem_write;
                act.iord        = bus_if.iord;
                act.reg_write   = bus_if.reg_write;
                act.reg_dst     = bus_if.reg_dst;
                act.mem_to_reg  = bus_if.mem_to_reg;
                act.halted      = bus_if.halted;
                tests++;
                if (act !== e) begin
                    fails++;
                    $display("FAIL step%0d outputs: got state=%0d vec=%b, required state=%0d vec=%b",
                             step_no, act.state, act, e.state, e);
                end
                step_no++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests            = 0;
        fails            = 0;
        reset            = 1'b1;
        bus_if.opcode    = 4'd0;
        bus_if.zero      = 1'b0;
        bus_if.mem_ready = 1'b1;
        repeat (2) @(posedge clk);

        // Reset cycle: FETCH decode with write strobes off
        cyc(4'd0, 4'd0, 1'b0, 1'b1, 1'b1);

        // R-type add: 0,1,2,4
        cyc(4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        cyc(4'd1, 4'd0, 1'b0, 1'b1, 1'b0);
        cyc(4'd2, 4'd0, 1'b0, 1'b1, 1'b0);
        cyc(4'd4, 4'd0, 1'b0, 1'b1, 1'b0);

        // R-type sub/and/or/slt
        for (int k = 1; k <= 4; k++) begin
            cyc(4'd0, 4'(k), 1'b0, 1'b1, 1'b0);
            cyc(4'd1, 4'(k), 1'b0, 1'b1, 1'b0);
            cyc(4'd2, 4'(k), 1'b0, 1'b1, 1'b0);
            cyc(4'd4, 4'(k), 1'b0, 1'b1, 1'b0);
        end

        // ADDI with one FETCH wait cycle: 0,0,1,3,11
        cyc(4'd0, 4'd5, 1'b0, 1'b0, 1'b0);
        cyc(4'd0, 4'd5, 1'b0, 1'b1, 1'b0);
        cyc(4'd1, 4'd5, 1'b0, 1'b1, 1'b0);
        cyc(4'd3, 4'd5, 1'b0, 1'b1, 1'b0);
        cyc(4'd11, 4'd5, 1'b0, 1'b1, 1'b0);

        // LW with 3 wait cycles: 0,1,5,6,6,6,6,7
        cyc(4'd0, 4'd6, 1'b0, 1'b1, 1'b0);
        cyc(4'd1, 4'd6, 1'b0, 1'b1, 1'b0);
        cyc(4'd5, 4'd6, 1'b0, 1'b1, 1'b0);
        repeat (3) cyc(4'd6, 4'd6, 1'b0, 1'b0, 1'b0);
        cyc(4'd6, 4'd6, 1'b0, 1'b1, 1'b0);
        cyc(4'd7, 4'd6, 1'b0, 1'b1, 1'b0);

        // SW with 2 wait cycles: 0,1,5,8,8,8
        cyc(4'd0, 4'd7, 1'b0, 1'b1, 1'b0);
        cyc(4'd1, 4'd7, 1'b0, 1'b1, 1'b0);
        cyc(4'd5, 4'd7, 1'b0, 1'b1, 1'b0);
        repeat (2) cyc(4'd8, 4'd7, 1'b0, 1'b0, 1'b0);
        cyc(4'd8, 4'd7, 1'b0, 1'b1, 1'b0);

        // BEQ taken then not taken
        cyc(4'd0, 4'd8, 1'b1, 1'b1, 1'b0);
        cyc(4'd1, 4'd8, 1'b1, 1'b1, 1'b0);
        cyc(4'd9, 4'd8, 1'b1, 1'b1, 1'b0);
        cyc(4'd0, 4'd8, 1'b0, 1'b1, 1'b0);
        cyc(4'd1, 4'd8, 1'b0, 1'b1, 1'b0);
        cyc(4'd9, 4'd8, 1'b0, 1'b1, 1'b0);

        // Jump
        cyc(4'd0, 4'd9, 1'b0, 1'b1, 1'b0);
        cyc(4'd1, 4'd9, 1'b0, 1'b1, 1'b0);
        cyc(4'd10, 4'd9, 1'b0, 1'b1, 1'b0);

        // Illegal opcodes 1011 and 1110 act as NOP
        cyc(4'd0, 4'd11, 1'b0, 1'b1, 1'b0);
        cyc(4'd1, 4'd11, 1'b0, 1'b1, 1'b0);
        cyc(4'd0, 4'd14, 1'b0, 1'b1, 1'b0);
        cyc(4'd1, 4'd14, 1'b0, 1'b1, 1'b0);

        // SW interrupted by reset during a MEM_WRITE wait
        cyc(4'd0, 4'd7, 1'b0, 1'b1, 1'b0);
        cyc(4'd1, 4'd7, 1'b0, 1'b1, 1'b0);
        cyc(4'd5, 4'd7, 1'b0, 1'b1, 1'b0);
        cyc(4'd8, 4'd7, 1'b0, 1'b0, 1'b0);
        cyc(4'd8, 4'd7, 1'b0, 1'b0, 1'b1);
        cyc(4'd0, 4'd7, 1'b0, 1'b1, 1'b0);

        // HALT held for 12 cycles, then a reset pulse
        cyc(4'd1, 4'd15, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++)
            cyc(4'd15, 4'd15, 1'(i % 2), 1'(i % 2), 1'b0);
        cyc(4'd15, 4'd15, 1'b0, 1'b1, 1'b1);
        cyc(4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending entries, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
